md_unit: RTL

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_pkg.sv | 41 ++++
 rtl/md_arith.sv | 54 +++++
 rtl/md_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared op encodings, op-class helpers and default latencies for the HI/LO multiply/divide unit.
package md_pkg;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  // Codes 0..7 are the multi-cycle arithmetic ops.
  function automatic logic is_arith(input logic [3:0] op);
    return (op[3] == 1'b0);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic is_accum(input logic [3:0] op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_sub(input logic [3:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational {HI,LO} result for the latched op: product, accumulate or quotient/remainder.
module md_arith
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   hi,
  input  logic [WIDTH-1:0]   lo,
  output logic [2*WIDTH-1:0] result
);

  logic               sgn;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] prod;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   ua;
  logic [WIDTH-1:0]   ub;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    sgn   = is_signed(op);
    // Sign-extending to 2*WIDTH makes one modular multiply serve both signednesses.
    ext_a = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    ext_b = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod  = ext_a * ext_b;

    a_neg = sgn && a[WIDTH-1];
    b_neg = sgn && b[WIDTH-1];
    ua    = a_neg ? -a : a;
    ub    = b_neg ? -b : b;
    quo   = '0;
    rem   = '0;
    if (ub != '0) begin
      quo = ua / ub;
      rem = ua % ub;
      if (a_neg ^ b_neg) quo = -quo;
      if (a_neg) rem = -rem;
    end

    result = prod;
    if (is_div(op)) begin
      result = {rem, quo};
    end else if (is_accum(op)) begin
      result = is_sub(op) ? ({hi, lo} - prod) : ({hi, lo} + prod);
    end
  end

endmodule

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit: fixed-latency arithmetic with a busy window, done pulse and flush.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             rd_hi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      cnt;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] result;

  logic               can_accept;
  logic               load;
  logic               wr_hi;
  logic               wr_lo;
  logic               commit;
  logic [CW-1:0]      lat;

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi     (hi),
    .lo     (lo),
    .result (result)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start && is_arith(op)) state_next = ST_RUN;
        ST_RUN:  if (cnt == CW'(1)) state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state == ST_RUN);
    can_accept = start && !busy && !flush;
    load       = can_accept && is_arith(op);
    wr_hi      = can_accept && (op == OP_MTHI);
    wr_lo      = can_accept && (op == OP_MTLO);
    commit     = busy && !flush && (cnt == CW'(1));
    lat        = is_div(op) ? CW'(DIV_LAT) : CW'(MULT_LAT);
  end

  // HI/LO only move on commit or an idle MTHI/MTLO, so accumulates see values as at acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      cnt  <= '0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      done <= 1'b0;
    end else begin
      done <= commit;
      if (flush) begin
        cnt <= '0;
      end else if (load) begin
        cnt  <= lat;
        op_q <= op;
        a_q  <= src_a;
        b_q  <= src_b;
      end else if (busy) begin
        cnt <= cnt - CW'(1);
      end
      if (commit) begin
        {hi, lo} <= result;
      end else if (wr_hi) begin
        hi <= src_a;
      end else if (wr_lo) begin
        lo <= src_a;
      end
    end
  end

  assign rd_data = rd_hi ? hi : lo;

endmodule
